frame_streamer: RTL and testbench

FRAME_STREAMER -- requirements
Module: frame_streamer

---
 rtl/lenet_pkg.sv | 20 ++
 rtl/axis_if.sv | 15 +
 rtl/axis_skid_fifo.sv | 44 ++++
 rtl/frame_streamer.sv | 130 +++++++++++++
 tb/tb_frame_streamer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// Shared image-geometry defaults and streaming-FSM state encoding for the
// frame-buffer readout blocks.
package lenet_pkg;

  localparam int DEF_IMG_WIDTH   = 32;
  localparam int DEF_IMG_HEIGHT  = 32;
  localparam int DEF_PIXEL_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } stream_state_t;

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream style video bus: tuser marks start-of-frame, tlast marks end-of-line.
interface axis_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport main (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport sub  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO that decouples frame-buffer read latency from downstream backpressure.
module axis_skid_fifo #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign pop_data = slot[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) slot[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/frame_streamer.sv
// Reads one frame row-major from an external 1-cycle-latency frame buffer and
// emits it as a video stream with start-of-frame and end-of-line markers.
module frame_streamer
  import lenet_pkg::*;
#(
  parameter  int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter  int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  localparam int ADDR_WIDTH  = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  mem_raddr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  axis_if.main                   image_out
);

  localparam int COL_W  = cnt_width(IMG_WIDTH);
  localparam int ROW_W  = cnt_width(IMG_HEIGHT);
  localparam int FIFO_W = PIXEL_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

  stream_state_t     state;
  logic              rd_vld_p1;
  logic [COL_W-1:0]  tag_col;
  logic [ROW_W-1:0]  tag_row;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] push_data;
  logic [FIFO_W-1:0] head;
  logic [2:0]        in_flight;
  logic              pop;
  logic              issue;
  logic              accept_last;

  assign pop       = ~fifo_empty & image_out.tready;
  assign in_flight = {1'b0, fifo_full, ~fifo_full & ~fifo_empty} + {2'b00, rd_vld_p1};
  // A pop in the same cycle frees a slot; counting it keeps the stream bubble-free.
  assign issue       = (state == STREAM) && ((in_flight < 3'd2) || ((in_flight == 3'd2) && pop));
  assign accept_last = pop && (row == LAST_ROW) && (col == LAST_COL);
  assign push_data   = {(tag_row == '0) && (tag_col == '0), tag_col == LAST_COL, mem_rdata};

  axis_skid_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (rd_vld_p1),
    .push_data(push_data),
    .full     (fifo_full),
    .pop      (pop),
    .pop_data (head),
    .empty    (fifo_empty)
  );

  assign image_out.tvalid = ~fifo_empty;
  assign image_out.tdata  = head[PIXEL_WIDTH-1:0];
  assign image_out.tlast  = head[PIXEL_WIDTH];
  assign image_out.tuser  = head[PIXEL_WIDTH+1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_raddr <= '0;
      rd_vld_p1 <= 1'b0;
      tag_col   <= '0;
      tag_row   <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      done      <= 1'b0;
      rd_vld_p1 <= issue;
      if (issue) mem_raddr <= mem_raddr + 1'b1;

      // push side: markers follow the pixel position of each returned read
      if (rd_vld_p1) begin
        if (tag_col == LAST_COL) begin
          tag_col <= '0;
          tag_row <= (tag_row == LAST_ROW) ? '0 : tag_row + 1'b1;
        end else begin
          tag_col <= tag_col + 1'b1;
        end
      end

      if (pop) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            busy      <= 1'b1;
            mem_raddr <= '0;
            tag_col   <= '0;
            tag_row   <= '0;
            col       <= '0;
            row       <= '0;
          end
        end
        STREAM: begin
          if (issue && (mem_raddr == LAST_ADDR)) state <= DRAIN;
        end
        DRAIN: begin
          if (accept_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: a 4x3 instance for directed scenarios
// and a default 32x32 instance under random backpressure.
module tb_frame_streamer;
  import lenet_pkg::*;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int PW  = 8;
  localparam int N   = W * H;
  localparam int AW  = $clog2(N);
  localparam int BN  = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int BAW = $clog2(BN);

  typedef struct packed {
    logic [PW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] mem_raddr;
  logic [PW-1:0] mem_rdata;
  axis_if #(.DATA_W(PW)) img ();

  logic           start_b = 1'b0;
  logic           busy_b, done_b;
  logic [BAW-1:0] raddr_b;
  logic [PW-1:0]  rdata_b;
  axis_if #(.DATA_W(PW)) img_b ();

  frame_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .image_out(img)
  );

  frame_streamer dut_b (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_raddr(raddr_b), .mem_rdata(rdata_b), .image_out(img_b)
  );

  function automatic logic [PW-1:0] pix_b(input int i);
    return PW'(i * 5 + (i >> 8));
  endfunction

  // Frame buffers: small one holds mem[i] = i, large one holds pix_b(i).
  always @(posedge clock) begin
    mem_rdata <= PW'(mem_raddr);
    rdata_b   <= pix_b(int'(raddr_b));
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // tready drivers: mode 0 = always 1, 1 = pattern 1,0,0,1, 2 = held 0
  int   rmode  = 0;
  int   phase  = 0;
  logic rand_b = 1'b0;
  initial begin
    img.tready   = 1'b1;
    img_b.tready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        0:       img.tready = 1'b1;
        1:       img.tready = ((phase % 4) == 0) || ((phase % 4) == 3);
        default: img.tready = 1'b0;
      endcase
      phase++;
      img_b.tready = rand_b ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  beat_t q[$];
  beat_t qb[$];
  int beats = 0, users = 0, lasts = 0, dones = 0;
  int first_vld_cyc = -1, first_acc_cyc = 0, last_acc_cyc = 0, start_cyc = 0;
  int beats_b = 0, users_b = 0, lasts_b = 0;

  // Monitor for the 4x3 instance.
  initial begin
    beat_t got, exp, held;
    logic  stall_p;
    stall_p = 1'b0;
    held    = '0;
    forever begin
      @(negedge clock);
      got = '{data: img.tdata, user: img.tuser, last: img.tlast};
      if (reset) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p) begin
          check("stall_tvalid", img.tvalid, 1);
          check("stall_hold", got, held);
        end
        if (img.tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (img.tvalid && img.tready) begin
          beats++;
          if (got.user) begin
            users++;
            first_acc_cyc = cyc;
          end
          if (got.last) lasts++;
          last_acc_cyc = cyc;
          check("beat_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            exp = q.pop_front();
            check("beat_content", got, exp);
          end
        end
        stall_p = img.tvalid & ~img.tready;
        held    = got;
        if (done) dones++;
      end
    end
  end

  // Monitor for the 32x32 instance.
  initial begin
    beat_t got, exp;
    forever begin
      @(negedge clock);
      if (!reset && img_b.tvalid && img_b.tready) begin
        got = '{data: img_b.tdata, user: img_b.tuser, last: img_b.tlast};
        beats_b++;
        if (got.user) users_b++;
        if (got.last) lasts_b++;
        check("big_beat_expected", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          exp = qb.pop_front();
          check("big_beat_content", got, exp);
        end
      end
    end
  end

  int s_beats, s_users, s_lasts, s_dones;

  task automatic start_frame();
    for (int i = 0; i < N; i++)
      q.push_back('{data: PW'(i), user: (i == 0), last: (i == 3 || i == 7 || i == 11)});
    s_beats = beats;
    s_users = users;
    s_lasts = lasts;
    s_dones = dones;
    first_vld_cyc = -1;
    start     = 1'b1;
    start_cyc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      step(1);
      k++;
    end
    check(name, done, 1);
  endtask

  task automatic wait_beats(input string name, input int target);
    int k = 0;
    while ((beats - s_beats) < target && k < 100) begin
      step(1);
      k++;
    end
    check(name, beats - s_beats, target);
  endtask

  task automatic frame_stats(input string tag);
    step(1);
    check({tag, "_beats"}, beats - s_beats, 12);
    check({tag, "_tuser"}, users - s_users, 1);
    check({tag, "_tlast"}, lasts - s_lasts, 3);
    check({tag, "_done_pulses"}, dones - s_dones, 1);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_queue_left"}, q.size(), 0);
  endtask

  initial begin
    int b_after, d_after, k;

    // Reset state
    step(3);
    check("rst_tvalid", img.tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_raddr", mem_raddr, 0);
    reset = 1'b0;
    step(2);

    // Full-throughput frame
    rmode = 0;
    start_frame();
    check("t1_busy", busy, 1);
    check("t1_raddr_first", mem_raddr, 0);
    wait_done("t1_done", 100);
    check("t1_first_tvalid_latency", first_vld_cyc - start_cyc, 3);
    check("t1_no_bubbles", last_acc_cyc - first_acc_cyc, N - 1);
    check("t1_done_after_last", cyc - last_acc_cyc, 1);
    check("t1_busy_at_done", busy, 0);
    frame_stats("t1");
    step(3);

    // Stall pattern 1,0,0,1
    rmode = 1;
    start_frame();
    wait_done("t2_done", 200);
    frame_stats("t2");
    rmode = 0;
    step(3);

    // Long stall after first tvalid
    rmode = 2;
    step(2);
    start_frame();
    k = 0;
    while (!img.tvalid && k < 10) begin
      step(1);
      k++;
    end
    check("t3_tvalid_rise", img.tvalid, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t3_raddr_hold", mem_raddr, 2);
    end
    rmode = 0;
    wait_done("t3_done", 100);
    frame_stats("t3");
    step(3);

    // Start while busy
    start_frame();
    wait_beats("t4_reach_beat5", 5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done("t4_done", 100);
    frame_stats("t4");
    step(5);
    check("t4_no_extra_beats", beats - s_beats, 12);
    check("t4_idle_busy", busy, 0);
    start_frame();
    wait_done("t4b_done", 100);
    frame_stats("t4b");
    step(3);

    // Reset mid-frame
    start_frame();
    wait_beats("t5_reach_beat6", 6);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t5_tvalid_after_reset", img.tvalid, 0);
    check("t5_busy_after_reset", busy, 0);
    q.delete();
    b_after = beats;
    d_after = dones;
    step(20);
    check("t5_no_beats_after_abort", beats, b_after);
    check("t5_no_done_after_abort", dones, d_after);
    start_frame();
    check("t5_restart_raddr", mem_raddr, 0);
    wait_done("t5_done", 100);
    frame_stats("t5");

    // Default 32x32 frame, random backpressure
    for (int i = 0; i < BN; i++)
      qb.push_back('{data: pix_b(i), user: (i == 0), last: ((i % 32) == 31)});
    rand_b  = 1'b1;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    k = 0;
    while (!done_b && k < 20000) begin
      step(1);
      k++;
    end
    check("t6_done", done_b, 1);
    rand_b = 1'b0;
    step(2);
    check("t6_beats", beats_b, BN);
    check("t6_tuser", users_b, 1);
    check("t6_tlast", lasts_b, 32);
    check("t6_queue_left", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
